// File: rtl/stack_param.sv
// rtl/stack_param.sv - parametrised LIFO stack with occupancy count, almost-full and sticky error flags (optional STACK_REG_OUT_EN registered read port)
module stack_param #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   stack_ptr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  do_push, do_pop, do_replace, do_push_empty;
    logic                  ovf_evt, udf_evt;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [CW-1:0]         top_cnt;
    logic [ADDR_WIDTH-1:0] top_addr;

    // Flags decoded straight from the registered count
    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == DEPTH_CNT);
        almost_full = (count_q >= AFULL_CNT);
        stack_ptr   = count_q;
        overflow    = overflow_q;
        underflow   = underflow_q;
    end

    // Classify the requested operation against the current occupancy
    always_comb begin
        do_push       = push & ~pop & ~full;
        ovf_evt       = push & ~pop & full;
        do_pop        = pop & ~push & ~empty;
        udf_evt       = pop & ~push & empty;
        do_replace    = push & pop & ~empty;
        do_push_empty = push & pop & empty;
        top_cnt       = count_q - ONE_CNT;
        top_addr      = top_cnt[ADDR_WIDTH-1:0];
        wr_en         = do_push | do_replace | do_push_empty;
        wr_addr       = do_replace ? top_addr : count_q[ADDR_WIDTH-1:0];
    end

    // Next-state for the occupancy count and the sticky error flags (set beats clear)
    always_comb begin
        count_d = count_q;
        if (do_push || do_push_empty) begin
            count_d = count_q + ONE_CNT;
        end else if (do_pop) begin
            count_d = count_q - ONE_CNT;
        end
        overflow_d  = ovf_evt ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
        underflow_d = udf_evt ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents deliberately left unreset, writes suppressed during reset
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef STACK_REG_OUT_EN
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [CW-1:0]         new_top_cnt;
    logic [ADDR_WIDTH-1:0] new_top_addr;

    // Post-operation top value, forwarding wr_data when it lands on the new top
    always_comb begin
        new_top_cnt  = count_d - ONE_CNT;
        new_top_addr = new_top_cnt[ADDR_WIDTH-1:0];
        if (count_d == '0) begin
            rd_d = '0;
        end else if (wr_en && (wr_addr == new_top_addr)) begin
            rd_d = wr_data;
        end else begin
            rd_d = mem[new_top_addr];
        end
    end

    // Registered read port, cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;
`else
    // Combinational read of the current top entry, zero when empty
    always_comb begin
        rd_data = empty ? '0 : mem[top_addr];
    end
`endif

endmodule
